// File: rtl/ctrl_vel_pid_mc.sv
// Multi-channel velocity PID: one shared GAIN_W x ERR_W multiplier time-multiplexed over NUM_CH axes,
// offset-binary DAC output with valid/ready. Define CTRL_VEL_FF_EN to add the Kff feed-forward term (MF state).
module ctrl_vel_pid_mc #(
    parameter int NUM_CH = 4,
    parameter int ENC_W  = 26,
    parameter int ERR_W  = 32,
    parameter int GAIN_W = 32,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ctrl_en_i,
    input  logic [NUM_CH*ENC_W-1:0] enc_cmd_i,
    input  logic [NUM_CH-1:0]       enc_dir_cmd_i,
    input  logic [NUM_CH*ENC_W-1:0] enc_fb_i,
    input  logic [NUM_CH-1:0]       enc_dir_fb_i,
    input  logic [NUM_CH-1:0]       enc_val_rdy_i,
    input  logic                    cfg_we_i,
    input  logic [2:0]              cfg_ch_i,
    input  logic [2:0]              cfg_sel_i,
    input  logic [31:0]             cfg_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [2:0]              out_ch_o,
    output logic [OUT_W-1:0]        out_data_o,
    output logic [NUM_CH-1:0]       sat_o
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW  = GAIN_W + ERR_W + 1;
    localparam int SW  = OUT_W + 2;
    localparam logic [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [ERR_W:0] IMAX = {2'b00, {(ERR_W-1){1'b1}}};
    localparam logic signed [ERR_W:0] INEG = -IMAX;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ERR   = 4'd1;
    localparam logic [3:0] S_MP    = 4'd2;
    localparam logic [3:0] S_MI    = 4'd3;
    localparam logic [3:0] S_MD    = 4'd4;
    localparam logic [3:0] S_MF    = 4'd5;
    localparam logic [3:0] S_SUM   = 4'd6;
    localparam logic [3:0] S_CLAMP = 4'd7;
    localparam logic [3:0] S_OUT   = 4'd8;
    localparam logic [3:0] S_INTEG = 4'd9;

    // Symmetric clamp to +/-c, with c itself limited to the largest positive code.
    function automatic logic [OUT_W-1:0] clampv(input logic signed [PW-1:0] v, input logic [OUT_W-1:0] c);
        logic signed [PW-1:0] lim, nlim;
        lim  = $signed({{(PW-OUT_W){1'b0}}, (c > OMAX) ? OMAX : c});
        nlim = -lim;
        if (v > lim)       clampv = lim[OUT_W-1:0];
        else if (v < nlim) clampv = nlim[OUT_W-1:0];
        else               clampv = v[OUT_W-1:0];
    endfunction

    function automatic logic clampx(input logic signed [PW-1:0] v, input logic [OUT_W-1:0] c);
        logic signed [PW-1:0] lim, nlim;
        lim    = $signed({{(PW-OUT_W){1'b0}}, (c > OMAX) ? OMAX : c});
        nlim   = -lim;
        clampx = (v > lim) || (v < nlim);
    endfunction

    logic [NUM_CH-1:0] s1_q, s2_q, s3_q, pend_q, pend_d, rise, req;
    logic [3:0]        state_q, state_d;
    logic [CHW-1:0]    cur_q, last_q, sel, cfg_idx;
    logic              any;
    int                idx;

    logic signed [GAIN_W-1:0] kp_q [NUM_CH];
    logic signed [GAIN_W-1:0] ki_q [NUM_CH];
    logic signed [GAIN_W-1:0] kd_q [NUM_CH];
    logic [20:0]              shf_q [NUM_CH];
    logic [OUT_W-1:0]         ui_q [NUM_CH];
    logic [OUT_W-1:0]         up_q [NUM_CH];
    logic signed [ERR_W-1:0]  eprev_q [NUM_CH];
    logic signed [ERR_W-1:0]  ei_q [NUM_CH];

    logic signed [GAIN_W-1:0] g_kp_q, g_ki_q, g_kd_q;
    logic [20:0]              g_shf_q;
    logic [OUT_W-1:0]         g_ui_q, g_up_q;
    logic signed [ERR_W-1:0]  err_q;
    logic [OUT_W-1:0]         p_q, i_q, d_q, sum_q;
    logic                     satf_q;
    logic                     out_valid_q;
    logic [2:0]               out_ch_q;
    logic [OUT_W-1:0]         out_data_q;
    logic [NUM_CH-1:0]        sat_q;
`ifdef CTRL_VEL_FF_EN
    logic signed [GAIN_W-1:0] kff_q [NUM_CH];
    logic signed [GAIN_W-1:0] g_kff_q;
    logic signed [ERR_W-1:0]  cmd_q;
    logic [OUT_W-1:0]         f_q;
`endif

    logic [ENC_W-1:0]         cmd_mag, fb_mag;
    logic signed [ERR_W-1:0]  cmd_s, fb_s, err_c, ei_cur, ep_cur, ei_nxt;
    logic signed [ERR_W:0]    isum;
    logic signed [GAIN_W-1:0] mul_a;
    logic signed [ERR_W:0]    mul_b;
    logic [6:0]               mul_sh;
    logic signed [PW-1:0]     prod, prod_sh, sum_ext, fin_ext;
    logic signed [SW-1:0]     sum_w;
    logic [OUT_W-1:0]         fin;
    logic                     fin_x;

    assign rise    = s2_q & ~s3_q;
    assign req     = pend_q & ctrl_en_i;
    assign cfg_idx = CHW'(cfg_ch_i);
    assign ei_cur  = ei_q[cur_q];
    assign ep_cur  = eprev_q[cur_q];

    // Round-robin: search starts at the channel after the one served last.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!any && req[CHW'(idx)]) begin
                any = 1'b1;
                sel = CHW'(idx);
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (state_q == S_IDLE && any) pend_d[sel] = 1'b0;
        pend_d = pend_d | rise;
    end

    always_comb begin
        cmd_mag = enc_cmd_i[int'(cur_q)*ENC_W +: ENC_W];
        fb_mag  = enc_fb_i[int'(cur_q)*ENC_W +: ENC_W];
        cmd_s   = $signed({{(ERR_W-ENC_W){1'b0}}, cmd_mag});
        fb_s    = $signed({{(ERR_W-ENC_W){1'b0}}, fb_mag});
        if (enc_dir_cmd_i[cur_q]) cmd_s = -cmd_s;
        if (enc_dir_fb_i[cur_q])  fb_s  = -fb_s;
        err_c = cmd_s - fb_s;
    end

    always_comb begin
        mul_a  = g_kp_q;
        mul_b  = {err_q[ERR_W-1], err_q};
        mul_sh = g_shf_q[20:14];
        case (state_q)
            S_MI: begin
                mul_a  = g_ki_q;
                mul_b  = {ei_cur[ERR_W-1], ei_cur};
                mul_sh = g_shf_q[13:7];
            end
            S_MD: begin
                mul_a  = g_kd_q;
                mul_b  = {err_q[ERR_W-1], err_q} - {ep_cur[ERR_W-1], ep_cur};
                mul_sh = g_shf_q[6:0];
            end
`ifdef CTRL_VEL_FF_EN
            S_MF: begin
                mul_a = g_kff_q;
                mul_b = {cmd_q[ERR_W-1], cmd_q};
            end
`endif
            default: ;
        endcase
        prod    = PW'(mul_a) * PW'(mul_b);
        prod_sh = prod >>> mul_sh;
    end

    always_comb begin
        sum_w = $signed({{2{p_q[OUT_W-1]}}, p_q}) + $signed({{2{i_q[OUT_W-1]}}, i_q})
              + $signed({{2{d_q[OUT_W-1]}}, d_q});
`ifdef CTRL_VEL_FF_EN
        sum_w = sum_w + $signed({{2{f_q[OUT_W-1]}}, f_q});
`endif
        sum_ext = {{(PW-SW){sum_w[SW-1]}}, sum_w};
        fin_ext = {{(PW-OUT_W){sum_q[OUT_W-1]}}, sum_q};
        fin     = clampv(fin_ext, g_up_q);
        fin_x   = clampx(fin_ext, g_up_q);
    end

    always_comb begin
        isum = {ei_cur[ERR_W-1], ei_cur} + {err_q[ERR_W-1], err_q};
        if (isum > IMAX)      ei_nxt = IMAX[ERR_W-1:0];
        else if (isum < INEG) ei_nxt = INEG[ERR_W-1:0];
        else                  ei_nxt = isum[ERR_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any) state_d = S_ERR;
            S_ERR:   state_d = S_MP;
            S_MP:    state_d = S_MI;
            S_MI:    state_d = S_MD;
`ifdef CTRL_VEL_FF_EN
            S_MD:    state_d = S_MF;
            S_MF:    state_d = S_SUM;
`else
            S_MD:    state_d = S_SUM;
`endif
            S_SUM:   state_d = S_CLAMP;
            S_CLAMP: state_d = S_OUT;
            S_OUT:   if (out_ready_i) state_d = S_INTEG;
            S_INTEG: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Disabling the channel in service abandons the cycle without an output.
        if (state_q != S_IDLE && !ctrl_en_i[cur_q]) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            pend_q      <= '0;
            state_q     <= S_IDLE;
            cur_q       <= '0;
            last_q      <= CHW'(NUM_CH-1);
            err_q       <= '0;
            g_kp_q      <= '0;
            g_ki_q      <= '0;
            g_kd_q      <= '0;
            g_shf_q     <= '0;
            g_ui_q      <= OMAX;
            g_up_q      <= OMAX;
            p_q         <= '0;
            i_q         <= '0;
            d_q         <= '0;
            sum_q       <= '0;
            satf_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= {1'b1, {(OUT_W-1){1'b0}}};
            sat_q       <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                kp_q[ch]    <= '0;
                ki_q[ch]    <= '0;
                kd_q[ch]    <= '0;
                shf_q[ch]   <= '0;
                ui_q[ch]    <= OMAX;
                up_q[ch]    <= OMAX;
                eprev_q[ch] <= '0;
                ei_q[ch]    <= '0;
            end
`ifdef CTRL_VEL_FF_EN
            g_kff_q <= '0;
            cmd_q   <= '0;
            f_q     <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) kff_q[ch] <= '0;
`endif
        end else begin
            s1_q    <= enc_val_rdy_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            state_q <= state_d;

            if (cfg_we_i && (int'(cfg_ch_i) < NUM_CH)) begin
                case (cfg_sel_i)
                    3'd0: kp_q[cfg_idx]  <= $signed(cfg_data_i[GAIN_W-1:0]);
                    3'd1: ki_q[cfg_idx]  <= $signed(cfg_data_i[GAIN_W-1:0]);
                    3'd2: kd_q[cfg_idx]  <= $signed(cfg_data_i[GAIN_W-1:0]);
                    3'd3: shf_q[cfg_idx] <= cfg_data_i[20:0];
                    3'd4: begin
                        ui_q[cfg_idx] <= cfg_data_i[16 +: OUT_W];
                        up_q[cfg_idx] <= cfg_data_i[0 +: OUT_W];
                    end
`ifdef CTRL_VEL_FF_EN
                    3'd5: kff_q[cfg_idx] <= $signed(cfg_data_i[GAIN_W-1:0]);
`endif
                    default: ;
                endcase
            end

            case (state_q)
                S_IDLE: if (any) begin
                    cur_q  <= sel;
                    last_q <= sel;
                end
                S_ERR: begin
                    err_q   <= err_c;
                    g_kp_q  <= kp_q[cur_q];
                    g_ki_q  <= ki_q[cur_q];
                    g_kd_q  <= kd_q[cur_q];
                    g_shf_q <= shf_q[cur_q];
                    g_ui_q  <= ui_q[cur_q];
                    g_up_q  <= up_q[cur_q];
                    satf_q  <= 1'b0;
`ifdef CTRL_VEL_FF_EN
                    g_kff_q <= kff_q[cur_q];
                    cmd_q   <= cmd_s;
`endif
                end
                S_MP: begin
                    p_q    <= clampv(prod_sh, g_up_q);
                    satf_q <= satf_q | clampx(prod_sh, g_up_q);
                end
                S_MI: i_q <= clampv(prod_sh, g_ui_q);
                S_MD: begin
                    d_q    <= clampv(prod_sh, g_up_q);
                    satf_q <= satf_q | clampx(prod_sh, g_up_q);
                end
`ifdef CTRL_VEL_FF_EN
                S_MF: f_q <= clampv(prod_sh, OMAX);
`endif
                S_SUM: sum_q <= clampv(sum_ext, OMAX);
                S_CLAMP: begin
                    out_valid_q  <= 1'b1;
                    out_ch_q     <= 3'(cur_q);
                    out_data_q   <= {~fin[OUT_W-1], fin[OUT_W-2:0]};
                    satf_q       <= satf_q | fin_x;
                    sat_q[cur_q] <= satf_q | fin_x;
                end
                S_OUT: if (out_ready_i) out_valid_q <= 1'b0;
                S_INTEG: begin
                    // A clamped output freezes the integrator (anti-windup).
                    if (!satf_q) ei_q[cur_q] <= ei_nxt;
                    eprev_q[cur_q] <= err_q;
                end
                default: ;
            endcase

            if (state_q != S_IDLE && !ctrl_en_i[cur_q]) out_valid_q <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (!ctrl_en_i[ch]) begin
                    eprev_q[ch] <= '0;
                    ei_q[ch]    <= '0;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;
    assign out_data_o  = out_data_q;
    assign sat_o       = sat_q;
endmodule

// File: tb/tb_ctrl_vel_pid_mc.sv
// Directed bench for ctrl_vel_pid_mc: P/I paths, clamping, arbitration, sign bits, abort and reset.
module tb_ctrl_vel_pid_mc;
    localparam int NUM_CH = 4;
    localparam int ENC_W  = 26;
    localparam int OUT_W  = 16;
`ifdef CTRL_VEL_FF_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 10;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       ctrl_en;
    logic [NUM_CH*ENC_W-1:0] enc_cmd;
    logic [NUM_CH-1:0]       enc_dir_cmd;
    logic [NUM_CH*ENC_W-1:0] enc_fb;
    logic [NUM_CH-1:0]       enc_dir_fb;
    logic [NUM_CH-1:0]       enc_val_rdy;
    logic                    cfg_we;
    logic [2:0]              cfg_ch;
    logic [2:0]              cfg_sel;
    logic [31:0]             cfg_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [2:0]              out_ch;
    logic [OUT_W-1:0]        out_data;
    logic [NUM_CH-1:0]       sat;

    int total = 0;
    int bad   = 0;

    ctrl_vel_pid_mc dut (
        .clk(clk), .reset(reset), .ctrl_en_i(ctrl_en),
        .enc_cmd_i(enc_cmd), .enc_dir_cmd_i(enc_dir_cmd),
        .enc_fb_i(enc_fb), .enc_dir_fb_i(enc_dir_fb), .enc_val_rdy_i(enc_val_rdy),
        .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch),
        .out_data_o(out_data), .sat_o(sat)
    );

    always #5 clk = ~clk;

    task automatic cfg(input int ch, input int sel, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_sel = 3'(sel); cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic set_ch(input int ch, input int cmd, input int fb);
        enc_cmd[ch*ENC_W +: ENC_W] = ENC_W'((cmd < 0) ? -cmd : cmd);
        enc_dir_cmd[ch]            = (cmd < 0);
        enc_fb[ch*ENC_W +: ENC_W]  = ENC_W'((fb < 0) ? -fb : fb);
        enc_dir_fb[ch]             = (fb < 0);
    endtask

    // Raise sample requests and count clocks until out_valid appears.
    task automatic fire(input logic [NUM_CH-1:0] mask, output int n, output bit got);
        got = 1'b0; n = 0;
        @(negedge clk);
        enc_val_rdy = mask;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 3) enc_val_rdy = '0;
            if (out_valid) begin got = 1'b1; n = i; break; end
        end
        enc_val_rdy = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (out_ch !== 3'd0) begin bad++; $display("FAIL rst_ch: got %0d want 0", out_ch); end
        total++; if (out_data !== 16'h8000) begin bad++; $display("FAIL rst_data: got %h want 8000", out_data); end
        total++; if (sat !== 4'b0) begin bad++; $display("FAIL rst_sat: got %b want 0000", sat); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_prop;
        int n; bit got;
        cfg(0, 0, 32'd1);
        set_ch(0, 100, 40);
        fire(4'b0001, n, got);
        total++; if (!got) begin bad++; $display("FAIL prop_timeout: no out_valid within 40 clk"); end
        total++; if (n != LAT) begin bad++; $display("FAIL prop_latency: got %0d want %0d", n, LAT); end
        total++; if (out_ch !== 3'd0) begin bad++; $display("FAIL prop_ch: got %0d want 0", out_ch); end
        total++; if (out_data !== 16'h803C) begin bad++; $display("FAIL prop_data: got %h want 803c", out_data); end
    endtask

    task automatic test_integ;
        int n; bit got;
        logic [15:0] exp_d;
        cfg(1, 0, 32'd1);
        cfg(1, 1, 32'd1);
        set_ch(1, 5, 0);
        for (int k = 0; k < 3; k++) begin
            exp_d = 16'h8005 + 16'(5 * k);
            fire(4'b0010, n, got);
            total++;
            if (!got || out_data !== exp_d)
                begin bad++; $display("FAIL integ_%0d: got %h valid=%b want %h", k, out_data, got, exp_d); end
        end
    endtask

    task automatic test_clamp;
        int n; bit got;
        cfg(2, 0, 32'd1);
        cfg(2, 4, 32'h7FFF_1000);
        set_ch(2, 32'h5000, 0);
        fire(4'b0100, n, got);
        total++; if (!got || out_data !== 16'h9000) begin bad++; $display("FAIL clamp_data: got %h want 9000", out_data); end
        total++; if (sat !== 4'b0100) begin bad++; $display("FAIL clamp_sat: got %b want 0100", sat); end
        cfg(2, 0, 32'd0);
        cfg(2, 1, 32'd1);
        cfg(2, 4, 32'h7FFF_7FFF);
        fire(4'b0100, n, got);
        total++; if (!got || out_data !== 16'h8000) begin bad++; $display("FAIL clamp_hold_i: got %h want 8000", out_data); end
        total++; if (sat !== 4'b0000) begin bad++; $display("FAIL clamp_sat_clr: got %b want 0000", sat); end
    endtask

    task automatic test_arb;
        int n; bit got; bit stall_bad; bit seen_low;
        cfg(1, 1, 32'd0);
        set_ch(1, 10, 0);
        cfg(3, 0, 32'd1);
        set_ch(3, 30, 0);
        @(negedge clk);
        out_ready = 1'b0;
        fire(4'b1010, n, got);
        total++; if (!got || out_ch !== 3'd3) begin bad++; $display("FAIL arb_first_ch: got %0d want 3", out_ch); end
        total++; if (out_data !== 16'h801E) begin bad++; $display("FAIL arb_first_data: got %h want 801e", out_data); end
        stall_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_ch !== 3'd3 || out_data !== 16'h801E) stall_bad = 1'b1;
        end
        total++; if (stall_bad) begin bad++; $display("FAIL arb_stall: got held=0 want held=1"); end
        @(negedge clk);
        out_ready = 1'b1;
        seen_low = 1'b0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!out_valid) seen_low = 1'b1;
            else if (seen_low) begin got = 1'b1; break; end
        end
        total++; if (!got || out_ch !== 3'd1) begin bad++; $display("FAIL arb_second_ch: got %0d valid=%b want 1", out_ch, got); end
        total++; if (out_data !== 16'h800A) begin bad++; $display("FAIL arb_second_data: got %h want 800a", out_data); end
    endtask

    task automatic test_dir;
        int n; bit got;
        cfg(3, 0, 32'd2);
        set_ch(3, -50, 50);
        fire(4'b1000, n, got);
        total++; if (!got || out_data !== 16'h7F38) begin bad++; $display("FAIL dir_data: got %h want 7f38", out_data); end
        total++; if (n != LAT) begin bad++; $display("FAIL dir_latency: got %0d want %0d", n, LAT); end
    endtask

    task automatic test_ctrl_en;
        int n; bit got; bit seen;
        cfg(0, 0, 32'd0);
        cfg(0, 1, 32'd1);
        fire(4'b0001, n, got);
        total++; if (!got || out_data !== 16'h803C) begin bad++; $display("FAIL en_pre_i: got %h want 803c", out_data); end
        @(negedge clk);
        enc_val_rdy = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        enc_val_rdy = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ctrl_en[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL en_abort: got out_valid=1 want 0"); end
        ctrl_en[0] = 1'b1;
        fire(4'b0001, n, got);
        total++; if (!got || out_data !== 16'h8000) begin bad++; $display("FAIL en_cleared_i: got %h want 8000", out_data); end
    endtask

    task automatic test_ff;
        int n; bit got;
        logic [15:0] exp_d;
`ifdef CTRL_VEL_FF_EN
        exp_d = 16'h80A0;
`else
        exp_d = 16'h803C;
`endif
        cfg(0, 0, 32'd1);
        cfg(0, 1, 32'd0);
        cfg(0, 5, 32'd1);
        fire(4'b0001, n, got);
        total++; if (!got || out_data !== exp_d) begin bad++; $display("FAIL ff_data: got %h want %h", out_data, exp_d); end
    endtask

    task automatic test_reset_mid;
        int n; bit got;
        @(negedge clk);
        out_ready = 1'b0;
        fire(4'b0001, n, got);
        total++; if (!got) begin bad++; $display("FAIL midrst_pre: got out_valid=0 want 1"); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 16'h8000) begin bad++; $display("FAIL midrst_data: got %h want 8000", out_data); end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        fire(4'b0001, n, got);
        total++; if (!got || out_data !== 16'h8000) begin bad++; $display("FAIL midrst_gains: got %h want 8000", out_data); end
    endtask

    initial begin
        reset = 1'b1; ctrl_en = '1; out_ready = 1'b1;
        enc_cmd = '0; enc_dir_cmd = '0; enc_fb = '0; enc_dir_fb = '0; enc_val_rdy = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        test_reset;
        test_prop;
        test_integ;
        test_clamp;
        test_arb;
        test_dir;
        test_ctrl_en;
        test_ff;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
